latch_seq_ctrl: RTL and testbench
=================================

# latch_seq_ctrl

Synchronous sequencer for the staged data-latch bank. It accepts a start request and a valid/ready sample stream, and drives one-hot per-stage load enables so exactly STAGE samples land in stage 0..STAGE-1. It then holds a frame-valid indication until the downstream consumer acknowledges it, and pulses a clear to the downstream counter. All control is in the single `clk` domain; no stage is clocked by a derived signal.

## Interface
- `STAGE`, 8: number of latch stages per frame; ≥2.
- `DWIDTH`, 8: sample width.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  frame request; sampled only in IDLE.
- `abort`  in  1  return to IDLE from any state.
- `in_valid`  in  1  sample present.
- `in_data`  in  DWIDTH  sample.
- `in_ready`  out  1  block accepts a sample this cycle.
- `load_en`  out  STAGE  one-hot stage write enable; bit i writes stage i.
- `load_data`  out  DWIDTH  data to write into the stage selected by `load_en`.
- `frame_valid`  out  1  all STAGE stages hold the current frame.
- `frame_ack`  in  1  consumer has taken the frame.
- `cnt_clr`  out  1  one-cycle clear pulse to the downstream counter.
- `busy`  out  1  state ≠ IDLE.
- `start_err`  out  1  one-cycle pulse when `start` arrives outside IDLE.
- `frame_cnt`  out  16  completed-frame count; wraps at 2^16.

## Operation
- States: IDLE, LOAD, HOLD, CLEAR.
- **IDLE**
  - `start`=1 → LOAD; beat index `idx` ← 0.
  - `frame_ack` is ignored.
- **LOAD**
  - `in_ready`=1.
  - A beat is accepted when `in_valid & in_ready`.
  - On each beat, `load_en` = one-hot(`idx`) and `load_data` = `in_data`. Both are combinational in the same cycle.
  - Then `idx` ← `idx`+1.
  - The beat with `idx`=STAGE-1 moves the FSM to HOLD.
  - While no beat is accepted, `load_en` = 0.
- **HOLD**
  - `frame_valid`=1 and `in_ready`=0.
  - `frame_ack`=1 → CLEAR and `frame_cnt` ← `frame_cnt`+1 (modulo 2^16).
- **CLEAR**
  - `cnt_clr`=1 for exactly this one cycle.
  - Next state is always IDLE.
- **start outside IDLE**
  - `start`=1 in any state other than IDLE is ignored and raises `start_err` for one cycle.
  - This includes a `start` in the CLEAR cycle.
- **abort**
  - `abort`=1 has priority over every other input.
  - Next state is IDLE and `idx` ← 0.
  - `in_ready` and `load_en` are forced to 0 in the abort cycle, so no beat is accepted.
  - The partially loaded frame is discarded; `frame_cnt` is unchanged.
  - No `cnt_clr` pulse is generated.
- **Simultaneous inputs**
  - `start` and `abort` in IDLE: abort wins and the FSM stays in IDLE. No `start_err`, because the FSM is in IDLE.
  - `frame_ack` and `abort` in HOLD: abort wins and `frame_cnt` is not incremented.
- **Width rules**
  - `idx` is `$clog2(STAGE)` bits.
  - `idx` never exceeds STAGE-1 and never wraps within a frame.

## Timing
- Reset values:
  - state = IDLE, `idx` = 0, `frame_cnt` = 0.
  - `in_ready`, `load_en`, `frame_valid`, `cnt_clr`, `busy` and `start_err` all = 0.
  - `load_data` = `in_data` (combinational pass-through).
- Reset mid-frame behaves the same as abort, except that `frame_cnt` also clears.
- Registered outputs: state, `idx`, `frame_cnt`, `start_err`.
- State decodes: `frame_valid`, `cnt_clr`, `busy`, `in_ready`.
- Latency figures:
  - `start` to first possible beat: 1 cycle. `start` at edge n puts the FSM in LOAD after edge n, so `in_ready` is high in cycle n+1.
  - Minimum frame: 1 (start) + STAGE (beats) + 1 (HOLD with immediate ack) + 1 (CLEAR) = STAGE+3 cycles, i.e. 11 cycles for STAGE=8.
  - `frame_ack` to `cnt_clr`: next cycle.
  - `cnt_clr` to the earliest accepted `start`: next cycle (back in IDLE).
- Backpressure: `in_valid` may drop at any cycle during LOAD. There is no timeout.

## Structure
- Package `latch_pkg` holds:
  - enum `latch_state_t` {IDLE, LOAD, HOLD, CLEAR}, 2-bit encoding;
  - `FRAME_CNT_W = 16`.
- Sub-module `stage_onehot_dec #(STAGE)`:
  - input: `idx` and an enable;
  - output: the STAGE-bit one-hot `load_en`, which is all-zero when not enabled.
- Everything else (FSM, counters, handshake) lives in `latch_seq_ctrl`.

## Test plan
- **Reset, then a full frame.** `start` once, then 8 back-to-back beats with data 0x10..0x17.
  - `load_en` steps 0x01, 0x02, …, 0x80 with `load_data` matching each beat.
  - `frame_valid` goes high the cycle after the 8th beat.
  - `frame_ack` → `cnt_clr` pulse, then `frame_cnt`=1.
- **Backpressure.** Drop `in_valid` for 3 cycles after beat 4.
  - `load_en`=0 during the gap and `idx` holds at 4.
  - The frame completes after 8 accepted beats, with total LOAD time of 11 cycles.
- **Abort during LOAD after beat 5.**
  - Next cycle: IDLE, `busy`=0, no `cnt_clr`, `frame_cnt` unchanged.
  - A new `start` reloads from stage 0 (`load_en`=0x01 first).
- **Stray start.** Pulse `start` during LOAD and during HOLD.
  - `start_err` pulses for one cycle each time.
  - State and `idx` are unaffected.
- **Counter wrap.** Preload by running 65536 frames, or force `frame_cnt` to 0xFFFF and then complete one frame.
  - `frame_cnt` = 0x0000.
- **Async reset asserted in HOLD, between clock edges.**
  - All outputs take their reset values immediately, without waiting for a clock edge.
  - After release, `start` behaves normally.

Source files
------------

// File: rtl/latch_pkg.sv
// ============================================================================
// latch_pkg : shared types and widths for the staged latch-bank sequencer.
// Revision  : 1.0
// ============================================================================
`default_nettype none

package latch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    HOLD  = 2'd2,
    CLEAR = 2'd3
  } latch_state_t;

  localparam int FRAME_CNT_W = 16;

endpackage

`default_nettype wire

// File: rtl/stage_onehot_dec.sv
// ============================================================================
// stage_onehot_dec : beat index to one-hot stage enable, all-zero when idle.
// Revision         : 1.0
// ============================================================================
`default_nettype none

module stage_onehot_dec #(
  parameter int STAGE = 8,
  parameter int IDX_W = $clog2(STAGE)
) (
  input  logic [IDX_W-1:0] idx_i,
  input  logic             en_i,
  output logic [STAGE-1:0] onehot_o
);

  for (genvar i = 0; i < STAGE; i++) begin : g_bit
    assign onehot_o[i] = en_i && (idx_i == IDX_W'(i));
  end

endmodule

`default_nettype wire

// File: rtl/latch_seq_ctrl.sv
// ============================================================================
// latch_seq_ctrl : loads STAGE samples into a latch bank, holds frame-valid
//                  until acknowledged, then pulses a downstream counter clear.
// Revision       : 1.0
// ============================================================================
`default_nettype none

module latch_seq_ctrl
  import latch_pkg::*;
#(
  parameter int STAGE  = 8,
  parameter int DWIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic                   abort_i,
  input  logic                   in_valid_i,
  input  logic [DWIDTH-1:0]      in_data_i,
  output logic                   in_ready_o,
  output logic [STAGE-1:0]       load_en_o,
  output logic [DWIDTH-1:0]      load_data_o,
  output logic                   frame_valid_o,
  input  logic                   frame_ack_i,
  output logic                   cnt_clr_o,
  output logic                   busy_o,
  output logic                   start_err_o,
  output logic [FRAME_CNT_W-1:0] frame_cnt_o
);

  localparam int                IDX_W    = $clog2(STAGE);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(STAGE - 1);

  latch_state_t            state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [FRAME_CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic                    start_err_q, start_err_d;
  logic                    beat;

  // Abort gates the handshake so a beat can never land in an abort cycle.
  assign in_ready_o    = (state_q == LOAD) && !abort_i;
  assign beat          = in_ready_o && in_valid_i;
  assign frame_valid_o = (state_q == HOLD);
  assign cnt_clr_o     = (state_q == CLEAR);
  assign busy_o        = (state_q != IDLE);
  assign load_data_o   = in_data_i;
  assign start_err_o   = start_err_q;
  assign frame_cnt_o   = frame_cnt_q;

  stage_onehot_dec #(
    .STAGE (STAGE),
    .IDX_W (IDX_W)
  ) u_dec (
    .idx_i    (idx_q),
    .en_i     (beat),
    .onehot_o (load_en_o)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    frame_cnt_d = frame_cnt_q;
    start_err_d = start_i && (state_q != IDLE);

    if (abort_i) begin
      state_d = IDLE;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            state_d = LOAD;
            idx_d   = '0;
          end
        end
        LOAD: begin
          if (beat) begin
            if (idx_q == LAST_IDX) begin
              state_d = HOLD;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
        HOLD: begin
          if (frame_ack_i) begin
            state_d     = CLEAR;
            frame_cnt_d = frame_cnt_q + 1'b1;
          end
        end
        CLEAR: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      frame_cnt_q <= '0;
      start_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      frame_cnt_q <= frame_cnt_d;
      start_err_q <= start_err_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_latch_seq_ctrl.sv
// ============================================================================
// tb_latch_seq_ctrl : table-driven check of latch_seq_ctrl plus reset/wrap.
// Revision          : 1.0
// ============================================================================
`default_nettype none

module tb_latch_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, abort, in_valid, frame_ack;
  logic [7:0]  in_data;
  logic        in_ready, frame_valid, cnt_clr, busy, start_err;
  logic [7:0]  load_en, load_data;
  logic [15:0] frame_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  latch_seq_ctrl #(.STAGE(8), .DWIDTH(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start),
    .abort_i       (abort),
    .in_valid_i    (in_valid),
    .in_data_i     (in_data),
    .in_ready_o    (in_ready),
    .load_en_o     (load_en),
    .load_data_o   (load_data),
    .frame_valid_o (frame_valid),
    .frame_ack_i   (frame_ack),
    .cnt_clr_o     (cnt_clr),
    .busy_o        (busy),
    .start_err_o   (start_err),
    .frame_cnt_o   (frame_cnt)
  );

  typedef struct {
    bit        st, ab, v;
    bit [7:0]  d;
    bit        ack;
    bit        rdy;
    bit [7:0]  len;
    bit        fv, clr, bsy, serr;
    bit [15:0] cnt;
  } vec_t;

  vec_t vq[$];

  // Packed view: {rdy, load_en, load_data, fv, clr, busy, serr, cnt}
  function automatic logic [36:0] pk(input logic rdy, input logic [7:0] len,
                                     input logic [7:0] dat, input logic fv,
                                     input logic clr, input logic bsy,
                                     input logic serr, input logic [15:0] cnt);
    return {rdy, len, dat, fv, clr, bsy, serr, cnt};
  endfunction

  function automatic logic [36:0] actual();
    return pk(in_ready, load_en, load_data, frame_valid, cnt_clr, busy,
              start_err, frame_cnt);
  endfunction

  task automatic check(input string name, input logic [36:0] act,
                       input logic [36:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (rdy,len,data,fv,clr,busy,serr,cnt)",
               name, act, exp);
    end
  endtask

  task automatic add(input bit st, input bit ab, input bit v, input bit [7:0] d,
                     input bit ack, input bit rdy, input bit [7:0] len,
                     input bit fv, input bit clr, input bit bsy, input bit serr,
                     input bit [15:0] cnt);
    vec_t e;
    e.st = st; e.ab = ab; e.v = v; e.d = d; e.ack = ack;
    e.rdy = rdy; e.len = len; e.fv = fv; e.clr = clr; e.bsy = bsy;
    e.serr = serr; e.cnt = cnt;
    vq.push_back(e);
  endtask

  task automatic drive(input bit st, input bit ab, input bit v,
                       input bit [7:0] d, input bit ack);
    start = st; abort = ab; in_valid = v; in_data = d; frame_ack = ack;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 8'h5A, 0);
    #12;
    check("reset_values", actual(), pk(0, 8'h00, 8'h5A, 0, 0, 0, 0, 16'h0));
    @(negedge clk);
    rst = 1'b0;
    cyc();

    // Frame A: full back-to-back frame
    add(0,0,0,8'h00,0, 0,8'h00,0,0,0,0,16'd0);
    add(1,0,0,8'h00,0, 0,8'h00,0,0,0,0,16'd0);
    for (int k = 0; k < 8; k++)
      add(0,0,1,8'h10+8'(k),0, 1,8'(1<<k),0,0,1,0,16'd0);
    add(0,0,0,8'h00,0, 0,8'h00,1,0,1,0,16'd0);
    add(0,0,0,8'h00,1, 0,8'h00,1,0,1,0,16'd0);
    add(0,0,0,8'h00,0, 0,8'h00,0,1,1,0,16'd1);
    add(0,0,0,8'h00,1, 0,8'h00,0,0,0,0,16'd1);   // ack ignored in IDLE
    // Frame B: backpressure gap plus stray starts in LOAD, HOLD, CLEAR
    add(1,0,0,8'h00,0, 0,8'h00,0,0,0,0,16'd1);
    for (int k = 0; k < 4; k++)
      add(0,0,1,8'h20+8'(k),0, 1,8'(1<<k),0,0,1,0,16'd1);
    add(1,0,0,8'hAA,0, 1,8'h00,0,0,1,0,16'd1);
    add(0,0,0,8'hAB,0, 1,8'h00,0,0,1,1,16'd1);
    add(0,0,0,8'hAC,0, 1,8'h00,0,0,1,0,16'd1);
    for (int k = 4; k < 8; k++)
      add(0,0,1,8'h20+8'(k),0, 1,8'(1<<k),0,0,1,0,16'd1);
    add(1,0,0,8'h00,0, 0,8'h00,1,0,1,0,16'd1);
    add(0,0,0,8'h00,0, 0,8'h00,1,0,1,1,16'd1);
    add(0,0,0,8'h00,1, 0,8'h00,1,0,1,0,16'd1);
    add(1,0,0,8'h00,0, 0,8'h00,0,1,1,0,16'd2);
    add(0,0,0,8'h00,0, 0,8'h00,0,0,0,1,16'd2);
    // Frame C: abort after 5 beats, start+abort in IDLE, restart from stage 0
    add(1,0,0,8'h00,0, 0,8'h00,0,0,0,0,16'd2);
    for (int k = 0; k < 5; k++)
      add(0,0,1,8'h30+8'(k),0, 1,8'(1<<k),0,0,1,0,16'd2);
    add(0,1,1,8'h35,0, 0,8'h00,0,0,1,0,16'd2);
    add(0,0,0,8'h00,0, 0,8'h00,0,0,0,0,16'd2);
    add(1,1,0,8'h00,0, 0,8'h00,0,0,0,0,16'd2);
    add(0,0,0,8'h00,0, 0,8'h00,0,0,0,0,16'd2);
    add(1,0,0,8'h00,0, 0,8'h00,0,0,0,0,16'd2);
    add(0,0,1,8'h40,0, 1,8'h01,0,0,1,0,16'd2);
    add(0,1,0,8'h00,0, 0,8'h00,0,0,1,0,16'd2);
    add(0,0,0,8'h00,0, 0,8'h00,0,0,0,0,16'd2);
    // Frame D: ack and abort together in HOLD
    add(1,0,0,8'h00,0, 0,8'h00,0,0,0,0,16'd2);
    for (int k = 0; k < 8; k++)
      add(0,0,1,8'h50+8'(k),0, 1,8'(1<<k),0,0,1,0,16'd2);
    add(0,1,0,8'h00,1, 0,8'h00,1,0,1,0,16'd2);
    add(0,0,0,8'h00,0, 0,8'h00,0,0,0,0,16'd2);

    foreach (vq[i]) begin
      drive(vq[i].st, vq[i].ab, vq[i].v, vq[i].d, vq[i].ack);
      #1;
      check($sformatf("vec%0d", i), actual(),
            pk(vq[i].rdy, vq[i].len, vq[i].d, vq[i].fv, vq[i].clr,
               vq[i].bsy, vq[i].serr, vq[i].cnt));
      cyc();
    end

    // Async reset in HOLD, between edges
    drive(1, 0, 0, 8'h00, 0); cyc();
    for (int k = 0; k < 8; k++) begin
      drive(0, 0, 1, 8'h60 + 8'(k), 0); cyc();
    end
    drive(0, 0, 0, 8'h77, 0);
    #1;
    check("hold_before_rst", actual(), pk(0, 8'h00, 8'h77, 1, 0, 1, 0, 16'd2));
    #2 rst = 1'b1;
    #1;
    check("async_rst", actual(), pk(0, 8'h00, 8'h77, 0, 0, 0, 0, 16'd0));
    @(posedge clk);
    #3 rst = 1'b0;
    cyc();
    drive(1, 0, 0, 8'h00, 0); cyc();
    drive(0, 0, 1, 8'h70, 0);
    #1;
    check("start_after_rst", actual(), pk(1, 8'h01, 8'h70, 0, 0, 1, 0, 16'd0));
    cyc();
    for (int k = 1; k < 8; k++) begin
      drive(0, 0, 1, 8'h70 + 8'(k), 0); cyc();
    end
    drive(0, 0, 0, 8'h00, 1); cyc();
    drive(0, 0, 0, 8'h00, 0); cyc();
    #1;
    check("cnt_after_rst", actual(), pk(0, 8'h00, 8'h00, 0, 0, 0, 0, 16'd1));

    // Counter wrap: preload 0xFFFF in IDLE, complete one frame
    force dut.frame_cnt_q = 16'hFFFF;
    #1;
    release dut.frame_cnt_q;
    #1;
    check("cnt_preload", actual(), pk(0, 8'h00, 8'h00, 0, 0, 0, 0, 16'hFFFF));
    cyc();
    drive(1, 0, 0, 8'h00, 0); cyc();
    for (int k = 0; k < 8; k++) begin
      drive(0, 0, 1, 8'h80 + 8'(k), 0); cyc();
    end
    drive(0, 0, 0, 8'h00, 1); cyc();
    drive(0, 0, 0, 8'h00, 0);
    #1;
    check("cnt_wrap_clear", actual(), pk(0, 8'h00, 8'h00, 0, 1, 1, 0, 16'h0000));
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
